// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one peripheral_div among NREQ
// requesters. It runs the divider register protocol (write A, B, init, poll
// done, read result) for the granted requester and returns a one-cycle ack.
module div_sched #(
  parameter int         NREQ      = 2,
  parameter int         POLL_MAX  = 64,
  parameter logic [4:0] ADDR_A    = 5'h04,
  parameter logic [4:0] ADDR_B    = 5'h08,
  parameter logic [4:0] ADDR_INIT = 5'h0C,
  parameter logic [4:0] ADDR_RES  = 5'h10,
  parameter logic [4:0] ADDR_DONE = 5'h14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   a_in,
  input  logic [16*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          result,
  output logic                 err,
  output logic                 busy,
  output logic                 div_cs,
  output logic                 div_rd,
  output logic                 div_wr,
  output logic [4:0]           div_addr,
  output logic [15:0]          div_d_in,
  input  logic [31:0]          div_d_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(POLL_MAX + 1);

  // Every bus strobe state is followed by its own idle (GAP/CHK/CAP) state.
  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_GAP_A, S_WR_B, S_GAP_B, S_WR_INIT, S_GAP_INIT,
    S_POLL_RD, S_POLL_CHK, S_RES_RD, S_RES_CAP, S_RESP
  } state_t;

  state_t          r_state, w_nxt;
  logic [PW-1:0]   r_ptr, r_gnt;
  logic [15:0]     r_b;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_result;
  logic            r_err;
  logic [4:0]      r_addr;
  logic [15:0]     r_din;

  logic            w_hit;
  logic [PW-1:0]   w_sel;
  logic [PW:0]     w_idx;
  logic [15:0]     w_a, w_b;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_poll_to;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_poll_to = (w_cnt_inc == CW'(POLL_MAX));

  // Round-robin search: first requesting index at or after the pointer.
  always_comb begin
    w_hit = 1'b0;
    w_sel = r_ptr;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) w_idx = w_idx - (PW+1)'(NREQ);
      if (!w_hit && req[w_idx[PW-1:0]]) begin
        w_hit = 1'b1;
        w_sel = w_idx[PW-1:0];
      end
    end
  end

  // Operand mux for the candidate grant.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == PW'(i)) begin
        w_a = a_in[16*i +: 16];
        w_b = b_in[16*i +: 16];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_hit) w_nxt = (w_b == 16'h0) ? S_RESP : S_WR_A;
      S_WR_A:     w_nxt = S_GAP_A;
      S_GAP_A:    w_nxt = S_WR_B;
      S_WR_B:     w_nxt = S_GAP_B;
      S_GAP_B:    w_nxt = S_WR_INIT;
      S_WR_INIT:  w_nxt = S_GAP_INIT;
      S_GAP_INIT: w_nxt = S_POLL_RD;
      S_POLL_RD:  w_nxt = S_POLL_CHK;
      S_POLL_CHK: begin
        if (div_d_out[0])   w_nxt = S_RES_RD;
        else if (w_poll_to) w_nxt = S_RESP;
        else                w_nxt = S_POLL_RD;
      end
      S_RES_RD:   w_nxt = S_RES_CAP;
      S_RES_CAP:  w_nxt = S_RESP;
      S_RESP:     w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  // Transaction datapath: grant latch, poll counter, result capture, pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_hit) begin
          r_gnt    <= w_sel;
          r_b      <= w_b;
          r_err    <= (w_b == 16'h0);
          r_result <= '0;
          r_cnt    <= '0;
        end
        S_POLL_CHK: if (!div_d_out[0]) begin
          r_cnt <= w_cnt_inc;
          if (w_poll_to) r_err <= 1'b1;
        end
        S_RES_CAP: r_result <= div_d_out;
        S_RESP: begin
          r_ptr <= (r_gnt == PW'(NREQ-1)) ? '0 : r_gnt + PW'(1);
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Address/data are loaded on entry to a strobe state and held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      case (w_nxt)
        S_WR_A:    begin r_addr <= ADDR_A;    r_din <= w_a;      end
        S_WR_B:    begin r_addr <= ADDR_B;    r_din <= r_b;      end
        S_WR_INIT: begin r_addr <= ADDR_INIT; r_din <= 16'h0001; end
        S_POLL_RD: r_addr <= ADDR_DONE;
        S_RES_RD:  r_addr <= ADDR_RES;
        default: ;
      endcase
    end
  end

  // Output decode; result/err are forced to 0 outside the ack cycle.
  always_comb begin
    div_wr = (r_state == S_WR_A) || (r_state == S_WR_B) || (r_state == S_WR_INIT);
    div_rd = (r_state == S_POLL_RD) || (r_state == S_RES_RD);
    div_cs = div_wr || div_rd;
    busy   = (r_state != S_IDLE);
    result = (r_state == S_RESP) ? r_result : 32'h0;
    err    = (r_state == S_RESP) ? r_err : 1'b0;
    for (int i = 0; i < NREQ; i++)
      ack[i] = (r_state == S_RESP) && (r_gnt == PW'(i));
  end

  assign div_addr = r_addr;
  assign div_d_in = r_din;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: table of transactions against a behavioural divider,
// plus hand sequences for poll timeout and asynchronous reset mid-transaction.
module tb_div_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, req2;
  logic [31:0] a_in, b_in, a2, b2;
  logic [1:0]  ack, ack2;
  logic [31:0] result, result2;
  logic        err, busy, cs, rd, wr;
  logic        err2, busy2, cs2, rd2, wr2;
  logic [4:0]  addr, addr2;
  logic [15:0] din, din2;
  logic [31:0] dout;
  logic [31:0] dout2;

  always #5 clk = ~clk;

  div_sched #(.NREQ(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .result(result), .err(err), .busy(busy),
    .div_cs(cs), .div_rd(rd), .div_wr(wr), .div_addr(addr),
    .div_d_in(din), .div_d_out(dout));

  // Second instance with a short poll limit; its divider never reports done.
  div_sched #(.NREQ(2), .POLL_MAX(4)) u_dut_to (
    .clk(clk), .reset(reset), .req(req2), .a_in(a2), .b_in(b2),
    .ack(ack2), .result(result2), .err(err2), .busy(busy2),
    .div_cs(cs2), .div_rd(rd2), .div_wr(wr2), .div_addr(addr2),
    .div_d_in(din2), .div_d_out(dout2));

  assign dout2 = 32'h0;

  // Divider model + bus log for the main instance.
  int          done_after = 1;
  int          m_pc = 0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [21:0] blog[$];
  int          proto_bad = 0;
  logic        prev_cs = 1'b0;
  int          polls2 = 0, res2 = 0;

  initial dout = '0;

  always @(negedge clk) begin
    prev_cs <= cs;
    if (cs && (rd == wr)) proto_bad <= proto_bad + 1;
    if (!cs && (rd || wr)) proto_bad <= proto_bad + 1;
    if (cs && prev_cs) proto_bad <= proto_bad + 1;
    if (cs) begin
      blog.push_back({wr, addr, wr ? din : 16'h0});
      if (wr) begin
        case (addr)
          5'h04: m_a <= din;
          5'h08: m_b <= din;
          5'h0C: m_pc <= 0;
          default: ;
        endcase
      end else if (rd) begin
        case (addr)
          5'h14: begin
            m_pc <= m_pc + 1;
            dout <= (m_pc + 1 >= done_after) ? 32'h1 : 32'h0;
          end
          5'h10: dout <= (m_b != 0) ? {16'h0, m_a / m_b} : 32'h0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cs2 && rd2 && addr2 == 5'h14) polls2 <= polls2 + 1;
    if (cs2 && rd2 && addr2 == 5'h10) res2 <= res2 + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  rq;
    logic [15:0] a0, b0, a1, b1;
    int          da;
    int          idx;
    int          lat;
    logic [31:0] res;
    logic        er;
    int          polls;
    logic [1:0]  rq_after;
  } vec_t;

  vec_t vt[8];

  // Applies one row from an IDLE-cycle negedge; returns at the following IDLE negedge.
  task automatic run_row(input int r);
    vec_t v;
    logic [21:0] exp_q[$];
    logic [15:0] ea, eb;
    logic [1:0]  g_ack;
    logic [31:0] g_res;
    logic        g_err;
    int          lat;
    bit          got;
    v = vt[r];
    blog.delete();
    done_after = v.da;
    req  = v.rq;
    a_in = {v.a1, v.a0};
    b_in = {v.b1, v.b0};
    got = 0; lat = 0; g_ack = '0; g_res = '0; g_err = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("r%0d busy", r), {31'h0, busy}, 32'h1);
        a_in = 32'hDEAD_BEEF;
        b_in = 32'hDEAD_BEEF;
      end
      if (ack != 2'b00) begin
        got = 1; lat = c; g_ack = ack; g_res = result; g_err = err;
        req = v.rq_after;
      end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL r%0d ack_timeout actual=none required=ack", r);
      req = 2'b00;
      return;
    end
    chk($sformatf("r%0d ack", r), {30'h0, g_ack}, 32'h1 << v.idx);
    chk($sformatf("r%0d latency", r), lat, v.lat);
    chk($sformatf("r%0d result", r), g_res, v.res);
    chk($sformatf("r%0d err", r), {31'h0, g_err}, {31'h0, v.er});
    @(negedge clk);
    chk($sformatf("r%0d busy_idle", r), {31'h0, busy}, 32'h0);
    ea = (v.idx == 0) ? v.a0 : v.a1;
    eb = (v.idx == 0) ? v.b0 : v.b1;
    if (eb != 16'h0) begin
      exp_q.push_back({1'b1, 5'h04, ea});
      exp_q.push_back({1'b1, 5'h08, eb});
      exp_q.push_back({1'b1, 5'h0C, 16'h0001});
      for (int p = 0; p < v.polls; p++) exp_q.push_back({1'b0, 5'h14, 16'h0});
      if (!v.er) exp_q.push_back({1'b0, 5'h10, 16'h0});
    end
    chk($sformatf("r%0d bus_len", r), blog.size(), exp_q.size());
    for (int e = 0; e < exp_q.size() && e < blog.size(); e++)
      chk($sformatf("r%0d bus%0d", r, e), {10'h0, blog[e]}, {10'h0, exp_q[e]});
    chk($sformatf("r%0d protocol", r), proto_bad, 0);
  endtask

  initial begin
    logic [1:0]  g_ack;
    logic [31:0] g_res;
    logic        g_err;
    int          lat;
    bit          got;

    //       rq     a0       b0       a1       b1       da  idx lat res           er    polls after
    vt[0] = '{2'b11, 16'd20,  16'd4,   16'd9,   16'd3,   1,  0,  11, 32'd5,        1'b0, 1, 2'b11};
    vt[1] = '{2'b11, 16'd20,  16'd4,   16'd9,   16'd3,   1,  1,  11, 32'd3,        1'b0, 1, 2'b11};
    vt[2] = '{2'b11, 16'd20,  16'd4,   16'd9,   16'd3,   1,  0,  11, 32'd5,        1'b0, 1, 2'b00};
    vt[3] = '{2'b10, 16'd0,   16'd0,   16'd7,   16'd0,   1,  1,  1,  32'd0,        1'b1, 0, 2'b00};
    vt[4] = '{2'b01, 16'h000F,16'h0005,16'd0,   16'd0,   1,  0,  11, 32'h00000003, 1'b0, 1, 2'b00};
    vt[5] = '{2'b10, 16'd0,   16'd0,   16'd100, 16'd7,   5,  1,  19, 32'd14,       1'b0, 5, 2'b00};
    vt[6] = '{2'b01, 16'd100, 16'd10,  16'd0,   16'd0,   1,  0,  11, 32'd10,       1'b0, 1, 2'b00};
    vt[7] = '{2'b11, 16'h1234,16'h0010,16'd9,   16'd3,   1,  0,  11, 32'h00000123, 1'b0, 1, 2'b00};

    reset = 1'b0; req = '0; req2 = '0;
    a_in = '0; b_in = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {ack, err, busy, cs, rd, wr, 24'h0}, 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_addr_din", {11'h0, addr, din}, 32'h0);
    chk("reset_busy2", {31'h0, busy2}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) run_row(r);

    // Poll timeout on the POLL_MAX=4 instance.
    polls2 = 0; res2 = 0;
    req2 = 2'b01; a2 = {16'd0, 16'd50}; b2 = {16'd0, 16'd5};
    got = 0; lat = 0; g_ack = '0; g_res = '0; g_err = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (ack2 != 2'b00) begin
        got = 1; lat = c; g_ack = ack2; g_res = result2; g_err = err2; req2 = 2'b00;
      end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL to_ack_timeout actual=none required=ack");
      req2 = 2'b00;
    end else begin
      chk("to_ack", {30'h0, g_ack}, 32'h1);
      chk("to_latency", lat, 15);
      chk("to_err", {31'h0, g_err}, 32'h1);
      chk("to_result", g_res, 32'h0);
    end
    @(negedge clk);
    chk("to_polls", polls2, 4);
    chk("to_res_reads", res2, 0);
    chk("to_busy_idle", {31'h0, busy2}, 32'h0);

    // Asynchronous reset during POLL_RD of a requester-1 transaction.
    blog.delete();
    done_after = 100;
    req = 2'b10; a_in = {16'd50, 16'd0}; b_in = {16'd5, 16'd0};
    got = 0;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      if (cs && rd && addr == 5'h14) got = 1;
    end
    chk("rst_poll_seen", {31'h0, got}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_outs", {ack, err, busy, cs, rd, wr, 24'h0}, 32'h0);
    chk("rst_async_result", result, 32'h0);
    chk("rst_async_addr_din", {11'h0, addr, din}, 32'h0);
    req = 2'b00;
    blog.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_no_strobes", blog.size(), 0);
    chk("rst_idle_busy", {31'h0, busy}, 32'h0);

    // Pointer must be back at 0: both requesting grants requester 0.
    run_row(7);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
